// File: rtl/fft_frame_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_frame_scheduler_if
// Brief    : valid/ready/data stream bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface fft_frame_scheduler_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/fft_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_frame_scheduler
// Brief    : Ping-pong frame buffer that collects audio samples into frames
//            and streams complete frames to an FFT datapath.
// Revision : 1.0
// ============================================================================
module fft_frame_scheduler #(
    parameter int NSamples = 1024,
    parameter int W        = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    fft_frame_scheduler_if.slave   audio_input,
    fft_frame_scheduler_if.master  fft_input,
    output logic                   fft_last,
    input  wire logic              fft_done,
    output logic [15:0]            frame_count,
    output logic                   busy
);
    localparam int            AW       = $clog2(NSamples);
    localparam logic [AW-1:0] LAST_IDX = AW'(NSamples - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } rd_state_t;

    logic [W-1:0]  mem [2][NSamples];
    bank_state_t   r_bank_state [2];

    logic          r_wr_bank;
    logic [AW-1:0] r_wr_idx;
    logic          r_rd_bank;
    logic [AW-1:0] r_rd_idx;
    logic          r_fetch_done;

    rd_state_t     r_state;
    rd_state_t     w_state_nxt;

    logic          r_out_valid;
    logic          r_out_last;
    logic [W-1:0]  r_out_data;
    logic [15:0]   r_frame_count;

    logic          w_wr_en;
    logic          w_wr_last;
    logic          w_load;
    logic          w_last_hs;
    logic          w_release;
    logic          w_start;

    // ------------------------------------------------------------------
    // Writer side
    // ------------------------------------------------------------------
    assign audio_input.ready = !reset && (r_bank_state[r_wr_bank] != BANK_FULL);
    assign w_wr_en           = audio_input.valid && audio_input.ready;
    assign w_wr_last         = w_wr_en && (r_wr_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[r_wr_bank][r_wr_idx] <= audio_input.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (w_wr_en) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Writer and reader never touch the same bank in one cycle: the reader
    // only releases a FULL bank and the writer only writes a non-FULL one.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (reset) begin
                r_bank_state[b] <= BANK_EMPTY;
            end else if (w_release && (r_rd_bank == 1'(b))) begin
                r_bank_state[b] <= BANK_EMPTY;
            end else if (w_wr_en && (r_wr_bank == 1'(b))) begin
                r_bank_state[b] <= w_wr_last ? BANK_FULL : BANK_FILLING;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
        w_start     = 1'b0;
        w_last_hs   = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (r_bank_state[r_rd_bank] == BANK_FULL) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Refill the output register whenever it is empty or draining.
                w_load = !r_fetch_done && (!r_out_valid || fft_input.ready);
                if (r_out_valid && fft_input.ready && r_out_last) begin
                    w_last_hs   = 1'b1;
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (fft_done) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read datapath and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_bank     <= 1'b0;
            r_rd_idx      <= '0;
            r_fetch_done  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_start) begin
                r_fetch_done <= 1'b0;
            end
            if (w_load) begin
                r_rd_idx     <= r_rd_idx + 1'b1;
                r_fetch_done <= (r_rd_idx == LAST_IDX);
                r_out_valid  <= 1'b1;
                r_out_last   <= (r_rd_idx == LAST_IDX);
            end else if (r_out_valid && fft_input.ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_last_hs) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_out_data <= mem[r_rd_bank][r_rd_idx];
        end
    end

    assign fft_input.valid = r_out_valid;
    assign fft_input.data  = r_out_data;
    assign fft_last        = r_out_last;
    assign frame_count     = r_frame_count;

endmodule
`default_nettype wire
